// File: rtl/terminal_qsys_keys_pkg.sv
// Shared constants for the key input port: register offsets and edge-type encodings.
package terminal_qsys_keys_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Selects which debounced transitions count as a capture event.
    function automatic logic edge_hit(int edge_type, logic rise, logic fall);
        case (edge_type)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/terminal_qsys_keys_if.sv
// Avalon-MM slave bus of the key port, shared by the top level and its bench.
interface terminal_qsys_keys_if;
    // No valid/ready pair: a write happens on every clk edge where chipselect && !write_n
    // (no backpressure); readdata is registered from the address seen at the previous edge.
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n,
                    output writedata, input readdata);
    modport slave  (input address, input chipselect, input write_n,
                    input writedata, output readdata);
endinterface

// File: rtl/terminal_qsys_keys_debounce.sv
// One key bit: two-flop synchronizer, hold-time debouncer and single-cycle edge pulses.
module terminal_qsys_keys_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    // Pulses are combinational so the capture register sets on the same edge stable flips.
    assign accept     = (sync1 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise_pulse = accept & sync1;
    assign fall_pulse = accept & ~sync1;
    assign level      = stable;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync0  <= IDLE_LEVEL;
            sync1  <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            cnt    <= '0;
        end else begin
            sync0 <= in_raw;
            sync1 <= sync0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/terminal_qsys_keys.sv
// Avalon-MM key input port: debounced levels, maskable edge capture and level irq.
module terminal_qsys_keys
    import terminal_qsys_keys_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    terminal_qsys_keys_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [31:0]      rd_next;
    logic             wr_en;

    assign wr_en = bus.chipselect & ~bus.write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        terminal_qsys_keys_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_debounce (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_raw    (in_port[i]),
            .level     (level[i]),
            .rise_pulse(rise[i]),
            .fall_pulse(fall[i])
        );
        assign set_vec[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^bus.writedata[31:WIDTH];
    end

    assign clr_vec = (wr_en && bus.address == ADDR_EDGE_CAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign irq     = |(edge_cap & irq_mask);

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:     rd_next = 32'(level);
            ADDR_IRQ_MASK: rd_next = 32'(irq_mask);
            ADDR_EDGE_CAP: rd_next = 32'(edge_cap);
            default:       rd_next = '0;
        endcase
    end

    // A new capture is OR-ed in after the clear so a colliding W1C cannot drop an event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_IRQ_MASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            edge_cap     <= (edge_cap & ~clr_vec) | set_vec;
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_terminal_qsys_keys.sv
// Bench for terminal_qsys_keys: falling-edge and any-edge instances share stimulus and a window model.
module tb_terminal_qsys_keys;
    import terminal_qsys_keys_pkg::*;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '1;
    logic        irq_f;
    logic        irq_a;

    always #5 clk = ~clk;

    terminal_qsys_keys_if bus_f ();
    terminal_qsys_keys_if bus_a ();

    assign bus_f.address    = address;
    assign bus_f.chipselect = chipselect;
    assign bus_f.write_n    = write_n;
    assign bus_f.writedata  = writedata;
    assign bus_a.address    = address;
    assign bus_a.chipselect = chipselect;
    assign bus_a.write_n    = write_n;
    assign bus_a.writedata  = writedata;

    terminal_qsys_keys #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_FALL), .IDLE_LEVEL(1'b1))
        dut_f (.clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port), .irq(irq_f));
    terminal_qsys_keys #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_ANY), .IDLE_LEVEL(1'b1))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a));

    int checks = 0;
    int failures = 0;

    // Reference model: a level flips once the input seen through two flops has held the
    // opposite value for the last D edges (a sliding window over sampled raw inputs).
    logic [W-1:0] hist[$];
    logic [W-1:0] m_level = '1;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap_f = '0;
    logic [W-1:0] m_cap_a = '0;
    logic [31:0]  m_rd_f = '0;
    logic [31:0]  m_rd_a = '0;
    logic [W-1:0] set_f, set_a, clr;
    bit           all_diff;
    int           n;

    function automatic logic [31:0] reg_view(logic [1:0] a, logic [W-1:0] lvl,
                                             logic [W-1:0] msk, logic [W-1:0] cap);
        case (a)
            2'd0:    return 32'(lvl);
            2'd2:    return 32'(msk);
            2'd3:    return 32'(cap);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back('1);
            m_level = '1; m_mask = '0; m_cap_f = '0; m_cap_a = '0; m_rd_f = '0; m_rd_a = '0;
        end else begin
            m_rd_f = reg_view(address, m_level, m_mask, m_cap_f);
            m_rd_a = reg_view(address, m_level, m_mask, m_cap_a);
            hist.push_back(in_port);
            if (hist.size() > D + 2) void'(hist.pop_front());
            n = hist.size();
            set_f = '0; set_a = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (hist[n-1-j][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[b] = ~m_level[b];
                    set_a[b] = 1'b1;
                    if (!m_level[b]) set_f[b] = 1'b1;
                end
            end
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_cap_f = (m_cap_f & ~clr) | set_f;
            m_cap_a = (m_cap_a & ~clr) | set_a;
        end
    end

    // Driver tasks: all start and end just after a falling edge.
    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] rf, output logic [31:0] ra);
        address = a;
        @(negedge clk);
        rf = bus_f.readdata;
        ra = bus_a.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rf, ra;
        reset_n = 1'b0; in_port = '1;
        tick(3);
        checks++; if ({irq_f, irq_a, bus_f.readdata, bus_a.readdata} !== 66'd0) begin
            failures++; $display("FAIL reset_outputs got irq=%b%b rd=%h/%h exp 0", irq_f, irq_a, bus_f.readdata, bus_a.readdata); end
        reset_n = 1'b1;
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hF, 32'hF}) begin
            failures++; $display("FAIL reset_data got %h/%h exp 0000000f", rf, ra); end
        bus_read(2'd2, rf, ra);
        checks++; if ({rf, ra} !== 64'd0) begin
            failures++; $display("FAIL reset_mask got %h/%h exp 0", rf, ra); end
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra, irq_f, irq_a} !== 66'd0) begin
            failures++; $display("FAIL reset_cap got %h/%h irq=%b%b exp 0", rf, ra, irq_f, irq_a); end
    endtask

    task automatic test_clean_press();
        logic [31:0] rf, ra;
        bus_write(2'd2, 32'h4);
        in_port[2] = 1'b0;
        tick(5);
        checks++; if ({irq_f, irq_a} !== 2'b00) begin
            failures++; $display("FAIL press_irq_early got %b%b exp 00", irq_f, irq_a); end
        tick(1);
        checks++; if ({irq_f, irq_a} !== 2'b11) begin
            failures++; $display("FAIL press_irq_edge got %b%b exp 11", irq_f, irq_a); end
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h4, 32'h4}) begin
            failures++; $display("FAIL press_cap got %h/%h exp 4/4", rf, ra); end
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hB, 32'hB}) begin
            failures++; $display("FAIL press_data got %h/%h exp b/b", rf, ra); end
        in_port[2] = 1'b1;
        tick(D + 4);
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hF, 32'hF}) begin
            failures++; $display("FAIL release_data got %h/%h exp f/f", rf, ra); end
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_bounce();
        logic [31:0] rf, ra;
        in_port[0] = 1'b0; tick(3);
        in_port[0] = 1'b1; tick(1);
        in_port[0] = 1'b0; tick(3);
        in_port[0] = 1'b1; tick(D + 4);
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hF, 32'hF}) begin
            failures++; $display("FAIL bounce_data got %h/%h exp f/f", rf, ra); end
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== 64'd0) begin
            failures++; $display("FAIL bounce_cap got %h/%h exp 0/0", rf, ra); end
    endtask

    task automatic test_w1c();
        logic [31:0] rf, ra;
        in_port = 4'b1010; tick(D + 4);
        in_port = 4'b1111; tick(D + 4);
        bus_write(2'd2, 32'h4);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h5, 32'h5}) begin
            failures++; $display("FAIL w1c_start got %h/%h exp 5/5", rf, ra); end
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra, irq_f, irq_a} !== {32'h4, 32'h4, 2'b11}) begin
            failures++; $display("FAIL w1c_bit0 got %h/%h irq=%b%b exp 4/4 irq=11", rf, ra, irq_f, irq_a); end
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra, irq_f, irq_a} !== 66'd0) begin
            failures++; $display("FAIL w1c_bit2 got %h/%h irq=%b%b exp 0/0 irq=00", rf, ra, irq_f, irq_a); end
        in_port[1] = 1'b0; tick(D + 4);
        in_port[1] = 1'b1; tick(D + 4);
        bus_write(2'd2, 32'h2);
        checks++; if ({irq_f, irq_a} !== 2'b11) begin
            failures++; $display("FAIL mask_on_irq got %b%b exp 11", irq_f, irq_a); end
        bus_write(2'd2, 32'h0);
        checks++; if ({irq_f, irq_a} !== 2'b00) begin
            failures++; $display("FAIL mask_off_irq got %b%b exp 00", irq_f, irq_a); end
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h2, 32'h2}) begin
            failures++; $display("FAIL mask_off_cap got %h/%h exp 2/2", rf, ra); end
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_collision();
        logic [31:0] rf, ra;
        in_port[1] = 1'b0;
        tick(5);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h2, 32'h2}) begin
            failures++; $display("FAIL collision_set_wins got %h/%h exp 2/2", rf, ra); end
        in_port[1] = 1'b1; tick(D + 4);
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_edge_any();
        logic [31:0] rf, ra;
        in_port[3] = 1'b0; tick(D + 4);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h8, 32'h8}) begin
            failures++; $display("FAIL any_press got %h/%h exp 8/8", rf, ra); end
        bus_write(2'd3, 32'h8);
        in_port[3] = 1'b1; tick(D + 4);
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== {32'h0, 32'h8}) begin
            failures++; $display("FAIL any_release got %h/%h exp 0/8", rf, ra); end
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hF, 32'hF}) begin
            failures++; $display("FAIL ro_data got %h/%h exp f/f", rf, ra); end
        bus_read(2'd1, rf, ra);
        checks++; if ({rf, ra} !== 64'd0) begin
            failures++; $display("FAIL reserved_read got %h/%h exp 0/0", rf, ra); end
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rf, ra;
        in_port[0] = 1'b0; tick(2);
        reset_n = 1'b0; in_port[0] = 1'b1; tick(1);
        reset_n = 1'b1; tick(D + 4);
        bus_read(2'd0, rf, ra);
        checks++; if ({rf, ra} !== {32'hF, 32'hF}) begin
            failures++; $display("FAIL reset_mid_data got %h/%h exp f/f", rf, ra); end
        bus_read(2'd3, rf, ra);
        checks++; if ({rf, ra} !== 64'd0) begin
            failures++; $display("FAIL reset_mid_cap got %h/%h exp 0/0", rf, ra); end
    endtask

    task automatic test_random();
        logic [31:0] rf, ra;
        for (int it = 0; it < 60; it++) begin
            in_port = W'($urandom_range(0, 15));
            tick($urandom_range(1, 2 * D + 2));
            if ($urandom_range(0, 3) == 0)
                bus_write(($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3, 32'($urandom_range(0, 15)));
            bus_read(2'($urandom_range(0, 3)), rf, ra);
            checks++; if ({rf, ra} !== {m_rd_f, m_rd_a}) begin
                failures++; $display("FAIL random_read it=%0d got %h/%h exp %h/%h", it, rf, ra, m_rd_f, m_rd_a); end
            checks++; if ({irq_f, irq_a} !== {|(m_cap_f & m_mask), |(m_cap_a & m_mask)}) begin
                failures++; $display("FAIL random_irq it=%0d got %b%b exp %b%b", it, irq_f, irq_a,
                                     |(m_cap_f & m_mask), |(m_cap_a & m_mask)); end
        end
        in_port = '1; tick(D + 4);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rf, ra);
            checks++; if ({rf, ra} !== {m_rd_f, m_rd_a}) begin
                failures++; $display("FAIL random_final a=%0d got %h/%h exp %h/%h", a, rf, ra, m_rd_f, m_rd_a); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_w1c();
        test_collision();
        test_edge_any();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
